// File: rtl/famicom_pkg.sv
// Shared types and constants for the Famicom/NES pad emulator.
// Optional turbo (auto-fire) support is selected with the FAMICOM_TURBO_EN macro.
package famicom_pkg;

    // Pad protocol phase: waiting, latching live buttons, shifting bits out, frame finished.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_t;

    // Bit positions inside the joystick word, in the order the pad shifts them out.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int PAD_BITS = 8;

endpackage

// File: rtl/famicom_sync_edge.sv
// Brings an asynchronous control line into the clk domain through STAGES
// synchronizer flops, then one more flop to produce single-cycle rise/fall
// strobes. Edge-to-strobe-consumed latency is STAGES+1 clk.
module famicom_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain followed by the edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/famicom_pad_emu.sv
// Serial Famicom/NES game pad emulator for the daphne core's controller port.
// The core drives famicom_latch/famicom_pulse (asynchronous to clk); the pad
// answers on famicom_data with active-low button bits, A first, Right last.
// Protocol: a high latch snapshots the buttons (reloaded live while high);
// each pulse rise after the latch falls moves to the next bit; after 8 bits
// the line idles high until the next latch.
// Optional auto-fire on A/B is compiled in with FAMICOM_TURBO_EN.
module famicom_pad_emu
    import famicom_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TURBO_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] joy_buttons,
    input  logic       turbo_a,
    input  logic       turbo_b,
    input  logic       famicom_latch,
    input  logic       famicom_pulse,
    output logic       famicom_data,
    output logic [3:0] bit_index,
    output logic       pad_active
);

    localparam logic [3:0] IDX_LAST = 4'(PAD_BITS - 1);
    localparam int         TOW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TOW-1:0] TO_MAX  = TOW'(TIMEOUT_CYC);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYC - 1);

    logic latch_lvl, latch_rise, latch_fall;
    logic pulse_lvl, pulse_rise, pulse_fall;
    logic unused_pulse;

    famicom_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk      (clk),
        .rst_n    (reset_n),
        .async_in (famicom_latch),
        .level    (latch_lvl),
        .rise     (latch_rise),
        .fall     (latch_fall)
    );

    famicom_sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk      (clk),
        .rst_n    (reset_n),
        .async_in (famicom_pulse),
        .level    (pulse_lvl),
        .rise     (pulse_rise),
        .fall     (pulse_fall)
    );

    // Only the rising edge of the shift clock matters to the pad.
    assign unused_pulse = pulse_lvl ^ pulse_fall;

    logic [PAD_BITS-1:0] eff_buttons;

`ifdef FAMICOM_TURBO_EN
    localparam int TDW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [TDW-1:0] TURBO_LAST = TDW'(TURBO_DIV - 1);

    logic [TDW-1:0] turbo_cnt;
    logic           turbo_phase;
    logic           frame_phase;

    // Toggle the auto-fire phase every TURBO_DIV latch rises. The phase a
    // frame uses is captured when the previous latch falls, so a toggle on
    // this frame's rise first shows up in the following frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
            frame_phase <= 1'b0;
        end else begin
            if (latch_rise) begin
                if (turbo_cnt == TURBO_LAST) begin
                    turbo_cnt   <= '0;
                    turbo_phase <= ~turbo_phase;
                end else begin
                    turbo_cnt <= turbo_cnt + 1'b1;
                end
            end
            if (latch_fall) begin
                frame_phase <= turbo_phase;
            end
        end
    end

    // Merge auto-fire into A and B; all other buttons pass straight through.
    always_comb begin
        eff_buttons        = joy_buttons;
        eff_buttons[BTN_A] = joy_buttons[BTN_A] | (turbo_a & frame_phase);
        eff_buttons[BTN_B] = joy_buttons[BTN_B] | (turbo_b & frame_phase);
    end
`else
    logic unused_turbo;
    assign unused_turbo = turbo_a ^ turbo_b;
    assign eff_buttons  = joy_buttons;
`endif

    pad_state_t          state;
    logic [PAD_BITS-1:0] shreg;

    // Pad protocol FSM: latch always wins and restarts the frame; pulse
    // rises only advance the shift register while in SHIFT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shreg        <= '1;
            famicom_data <= 1'b1;
            bit_index    <= 4'd0;
        end else if (latch_lvl) begin
            state        <= LOAD;
            shreg        <= ~eff_buttons;
            famicom_data <= ~eff_buttons[BTN_A];
            bit_index    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                end
                LOAD: begin
                    if (latch_fall) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        shreg        <= {1'b1, shreg[PAD_BITS-1:1]};
                        famicom_data <= shreg[1];
                        bit_index    <= bit_index + 4'd1;
                        if (bit_index == IDX_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    famicom_data <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [TOW-1:0] to_cnt;

    // Poll watchdog: a latch rise marks the pad active; TIMEOUT_CYC quiet
    // cycles later it is declared inactive and the counter parks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt     <= '0;
            pad_active <= 1'b0;
        end else if (latch_rise) begin
            to_cnt     <= '0;
            pad_active <= 1'b1;
        end else begin
            if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt == TO_LAST) begin
                pad_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_famicom_pad_emu.sv
// Directed + randomized bench for famicom_pad_emu with a frame-level model:
// a latch snapshots the active-low effective buttons, pulse k reveals bit k,
// and anything past bit 7 reads 1. Honours FAMICOM_TURBO_EN.
module tb_famicom_pad_emu;

    localparam int SYNC = 2;
    localparam int TO   = 100;
    localparam int TDIV = 2;
    localparam int LAT  = SYNC + 3;

`ifdef FAMICOM_TURBO_EN
    localparam bit TURBO_ON = 1'b1;
`else
    localparam bit TURBO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] joy_buttons = 8'h00;
    logic       turbo_a = 1'b0;
    logic       turbo_b = 1'b0;
    logic       famicom_latch = 1'b0;
    logic       famicom_pulse = 1'b0;
    logic       famicom_data;
    logic [3:0] bit_index;
    logic       pad_active;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         rises = 0;
    int         n_pulses = 0;
    logic [7:0] exp_q[$];

    famicom_pad_emu #(
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TO),
        .TURBO_DIV   (TDIV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .joy_buttons   (joy_buttons),
        .turbo_a       (turbo_a),
        .turbo_b       (turbo_b),
        .famicom_latch (famicom_latch),
        .famicom_pulse (famicom_pulse),
        .famicom_data  (famicom_data),
        .bit_index     (bit_index),
        .pad_active    (pad_active)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Auto-fire phase seen by the frame started by latch rise number rise_no
    // (1-based since reset): the phase after rise_no-1 rises.
    function automatic logic [7:0] eff_model(input logic [7:0] joy, input logic ta,
                                             input logic tb, input int rise_no);
        logic [7:0] e;
        logic       ph;
        ph   = TURBO_ON && ((((rise_no - 1) / TDIV) % 2) == 1);
        e    = joy;
        e[0] = joy[0] | (ta & ph);
        e[1] = joy[1] | (tb & ph);
        return e;
    endfunction

    // Scoreboard: data expected after the load, then after each pulse.
    task automatic load_queue();
        logic [7:0] s;
        s = ~eff_model(joy_buttons, turbo_a, turbo_b, rises);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({7'b0, s[i]});
        exp_q.push_back(8'd1);
    endtask

    task automatic latch_on(input string tag);
        famicom_latch = 1'b1;
        rises++;
        n_pulses = 0;
        tick(LAT);
        load_queue();
        check({tag, ":load_data"}, {7'b0, famicom_data}, exp_q[0]);
        check({tag, ":load_idx"}, {4'b0, bit_index}, 8'd0);
    endtask

    task automatic latch_off(input string tag);
        logic [7:0] e;
        famicom_latch = 1'b0;
        tick(LAT);
        e = exp_q.pop_front();
        check({tag, ":post_latch"}, {7'b0, famicom_data}, e);
    endtask

    task automatic pulse_step(input string tag);
        logic [7:0] e;
        famicom_pulse = 1'b1;
        tick(LAT);
        n_pulses++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'd1;
        check($sformatf("%s:p%0d_data", tag, n_pulses), {7'b0, famicom_data}, e);
        check($sformatf("%s:p%0d_idx", tag, n_pulses), {4'b0, bit_index},
              (n_pulses > 8) ? 8'd8 : 8'(n_pulses));
        famicom_pulse = 1'b0;
        tick(SYNC + 1);
    endtask

    task automatic frame(input string tag, input int npulse);
        latch_on(tag);
        latch_off(tag);
        for (int i = 0; i < npulse; i++) pulse_step(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        rises = 0;
        tick(1);
    endtask

    logic [5:0] turbo_tab = 6'b110011;
    int         c;

    initial begin
        // Reset values
        #2 reset_n = 1'b0;
        tick(3);
        check("rst_data", {7'b0, famicom_data}, 8'd1);
        check("rst_idx", {4'b0, bit_index}, 8'd0);
        check("rst_active", {7'b0, pad_active}, 8'd0);
        reset_n = 1'b1;
        tick(2);

        // A only, full frame
        joy_buttons = 8'h01;
        frame("a_only", 8);
        check("a_only:final_idx", {4'b0, bit_index}, 8'd8);

        // Right only, extra pulses past the end of frame
        joy_buttons = 8'h80;
        frame("right", 10);

        // Re-latch mid-frame with a live joystick change while latch is high
        joy_buttons = 8'h5A;
        frame("relatch_a", 3);
        joy_buttons = 8'h01;
        latch_on("relatch_b");
        joy_buttons = 8'h02;
        tick(LAT);
        load_queue();
        check("relatch_b:live_reload", {7'b0, famicom_data}, exp_q[0]);
        latch_off("relatch_b");
        pulse_step("relatch_b");

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            joy_buttons = 8'($urandom);
            turbo_a     = 1'($urandom_range(0, 1));
            turbo_b     = 1'($urandom_range(0, 1));
            frame($sformatf("rnd%0d", f), $urandom_range(0, 10));
        end
        turbo_a = 1'b0;
        turbo_b = 1'b0;

        // Poll watchdog
        do_reset();
        famicom_latch = 1'b1;
        rises++;
        c = 0;
        while (!pad_active && c < 20) begin tick(1); c++; end
        check("to:rise_latency", 8'(c), 8'(SYNC + 1));
        c = 0;
        while (pad_active && c < 2 * TO) begin tick(1); c++; end
        check("to:drop_cycles", 8'(c), 8'(TO));
        famicom_latch = 1'b0;
        tick(LAT);
        famicom_latch = 1'b1;
        rises++;
        c = 0;
        while (!pad_active && c < 20) begin tick(1); c++; end
        check("to:rearm_latency", 8'(c), 8'(SYNC + 1));
        famicom_latch = 1'b0;
        tick(LAT);

        // Auto-fire over six frames
        do_reset();
        joy_buttons = 8'h00;
        turbo_a     = 1'b1;
        for (int f = 0; f < 6; f++) begin
            latch_on($sformatf("turbo%0d", f));
            check($sformatf("turbo%0d:a_bit", f), {7'b0, famicom_data},
                  TURBO_ON ? {7'b0, turbo_tab[f]} : 8'd1);
            latch_off($sformatf("turbo%0d", f));
        end
        turbo_a = 1'b0;

        // Asynchronous reset mid-frame, then a clean frame
        joy_buttons = 8'($urandom);
        frame("pre_rst", 4);
        check("pre_rst:active", {7'b0, pad_active}, 8'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst:data", {7'b0, famicom_data}, 8'd1);
        check("async_rst:idx", {4'b0, bit_index}, 8'd0);
        check("async_rst:active", {7'b0, pad_active}, 8'd0);
        tick(2);
        reset_n = 1'b1;
        rises = 0;
        tick(2);
        joy_buttons = 8'($urandom);
        frame("post_rst", 9);

        // Report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
